// File: rtl/scoreboard_disp_ctrl_if.sv
// Purpose : game-logic <-> scoreboard display controller signal bundle.
// Latency : n/a (wires only).
// Backpr. : none; all commands are single-cycle pulses or levels.
// Ports   : start/pause/score_inc/score_clr (commands toward the controller),
//           scan_en, d3..d0, time_up, state (controller outputs).
interface scoreboard_disp_ctrl_if;
    logic       start;
    logic       pause;
    logic       score_inc;
    logic       score_clr;
    logic       scan_en;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic       time_up;
    logic [1:0] state;

    // Game logic side issues commands and observes the display bus.
    modport master (
        output start, pause, score_inc, score_clr,
        input  scan_en, d3, d2, d1, d0, time_up, state
    );

    // Display controller side.
    modport slave (
        input  start, pause, score_inc, score_clr,
        output scan_en, d3, d2, d1, d0, time_up, state
    );
endinterface

// File: rtl/scoreboard_disp_ctrl.sv
// Purpose : shot-clock / score / game-state controller feeding the 4-digit seven-segment mux.
// Latency : every output is registered and changes on the clk edge that samples its cause.
// Backpr. : none; commands are accepted every cycle, scan_en is a free-running strobe.
// Ports   : clk, rst (sync, active-high); bus (slave modport): start, pause, score_inc,
//           score_clr in; scan_en, d3..d0 (BCD, 4'hF = blank), time_up, state out.
module scoreboard_disp_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int SEC_DIV    = 100000000,
    parameter int BLINK_DIV  = 50000000,
    parameter int START_TIME = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    scoreboard_disp_ctrl_if.slave   bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int SEC_W   = (SEC_DIV   > 1) ? $clog2(SEC_DIV)   : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // Reload value split into BCD digits once, at elaboration.
    localparam logic [3:0] ST_TENS = 4'(START_TIME / 10);
    localparam logic [3:0] ST_ONES = 4'(START_TIME % 10);
    localparam logic [3:0] BLANK   = 4'hF;

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [SEC_W-1:0]   sec_cnt_q,   sec_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_on_q,  blink_on_d;
    logic [3:0]         score_t_q,   score_t_d;
    logic [3:0]         score_o_q,   score_o_d;
    logic [3:0]         shot_t_q,    shot_t_d;
    logic [3:0]         shot_o_q,    shot_o_d;
    logic [1:0]         state_q,     state_d;
    logic               scan_en_q,   scan_en_d;
    logic               time_up_q,   time_up_d;
    logic [3:0]         d3_q, d3_d, d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;

    logic sec_tick;
    logic expire;

    assign sec_tick = (sec_cnt_q == SEC_LAST);
    assign expire   = sec_tick && (shot_t_q == 4'd0) && (shot_o_q == 4'd1);

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        scan_en_d   = 1'b0;
        sec_cnt_d   = sec_cnt_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        score_t_d   = score_t_q;
        score_o_d   = score_o_q;
        shot_t_d    = shot_t_q;
        shot_o_d    = shot_o_q;
        state_d     = state_q;
        time_up_d   = 1'b0;

        // Scan strobe is independent of game state.
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_en_d  = 1'b1;
        end

        // Score: clear wins over increment; increments only count while running.
        if (bus.score_clr) begin
            score_t_d = 4'd0;
            score_o_d = 4'd0;
        end else if (bus.score_inc && (state_q == ST_RUN) &&
                     !((score_t_q == 4'd9) && (score_o_q == 4'd9))) begin
            if (score_o_q == 4'd9) begin
                score_o_d = 4'd0;
                score_t_d = score_t_q + 4'd1;
            end else begin
                score_o_d = score_o_q + 4'd1;
            end
        end

        // start overrides every state, pause and a coincident expiry.
        if (bus.start) begin
            shot_t_d    = ST_TENS;
            shot_o_d    = ST_ONES;
            sec_cnt_d   = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
            state_d     = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (sec_tick) begin
                        sec_cnt_d = '0;
                        if (shot_o_q == 4'd0) begin
                            shot_o_d = 4'd9;
                            shot_t_d = shot_t_q - 4'd1;
                        end else begin
                            shot_o_d = shot_o_q - 4'd1;
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                    if (expire) begin
                        state_d     = ST_DONE;
                        time_up_d   = 1'b1;
                        blink_cnt_d = '0;
                        blink_on_d  = 1'b1;
                    end else if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_on_d  = !blink_on_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Digits come from next-state values so the display tracks the state edge.
        d3_d = (score_t_d == 4'd0) ? BLANK : score_t_d;
        d2_d = score_o_d;
        if (state_d == ST_DONE) begin
            d1_d = BLANK;
            d0_d = blink_on_d ? 4'd0 : BLANK;
        end else begin
            d1_d = (shot_t_d == 4'd0) ? BLANK : shot_t_d;
            d0_d = shot_o_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q  <= '0;
            sec_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            score_t_q   <= 4'd0;
            score_o_q   <= 4'd0;
            shot_t_q    <= ST_TENS;
            shot_o_q    <= ST_ONES;
            state_q     <= ST_IDLE;
            scan_en_q   <= 1'b0;
            time_up_q   <= 1'b0;
            d3_q        <= BLANK;
            d2_q        <= 4'd0;
            d1_q        <= (ST_TENS == 4'd0) ? BLANK : ST_TENS;
            d0_q        <= ST_ONES;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            score_t_q   <= score_t_d;
            score_o_q   <= score_o_d;
            shot_t_q    <= shot_t_d;
            shot_o_q    <= shot_o_d;
            state_q     <= state_d;
            scan_en_q   <= scan_en_d;
            time_up_q   <= time_up_d;
            d3_q        <= d3_d;
            d2_q        <= d2_d;
            d1_q        <= d1_d;
            d0_q        <= d0_d;
        end
    end

    assign bus.scan_en = scan_en_q;
    assign bus.time_up = time_up_q;
    assign bus.state   = state_q;
    assign bus.d3      = d3_q;
    assign bus.d2      = d2_q;
    assign bus.d1      = d1_q;
    assign bus.d0      = d0_q;
endmodule

// File: doc/scoreboard_disp_ctrl.md
Name: scoreboard_disp_ctrl

Overview:
- Controller that sequences the 4-digit seven-segment mux for the shot simulator.
- Owns the shot-clock countdown, the made-shot score and the game state. Generates the mux scan strobe and drives the mux digit inputs d3..d0 as BCD, using 4'hF as the blank code.
- Sits between the game logic (start / pause / score pulses) and sevenseg_mux.
- Display layout: d3,d2 = score; d1,d0 = shot clock.

Parameters:
- SCAN_DIV, 100000: clk cycles between scan_en pulses (1 kHz at 100 MHz).
- SEC_DIV, 100000000: clk cycles per shot-clock second.
- BLINK_DIV, 50000000: clk cycles per blink half-period in DONE.
- START_TIME, 24: shot-clock reload value in seconds. Legal range 1..99, binary; tens/ones are split at elaboration.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle pulse; reload the shot clock and enter RUN.
- pause, input, 1: level; while high in RUN/PAUSE, the countdown is frozen.
- score_inc, input, 1: single-cycle pulse; add 1 to the score.
- score_clr, input, 1: single-cycle pulse; score to 0.
- scan_en, output, 1: single-cycle strobe to sevenseg_mux.
- d3, output, 4: score tens (BCD or F).
- d2, output, 4: score ones (BCD).
- d1, output, 4: shot-clock tens (BCD or F).
- d0, output, 4: shot-clock ones (BCD or F).
- time_up, output, 1: single-cycle pulse when the shot clock expires.
- state, output, 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- All outputs registered. Every output change follows the causing clk edge by 1 cycle.
- Reset values:
  - scan_en=0, time_up=0, state=IDLE.
  - score=0, so d3=F, d2=0.
  - Shot clock = START_TIME, d1/d0 = its digits with leading-zero blanking.
  - Scan, second and blink counters = 0.
- Scan divider:
  - Free-running in all states.
  - Counter runs 0..SCAN_DIV-1; scan_en=1 for exactly the cycle after the counter reaches SCAN_DIV-1.
  - First pulse occurs SCAN_DIV cycles after rst deasserts.
- Score:
  - Two BCD registers; no binary divide.
  - score_inc is honoured only in RUN. Ones wraps 9->0 with a carry into tens. Saturates at 99.
  - score_clr is honoured in any state and has priority over a simultaneous score_inc.
- Shot clock: two BCD registers plus a second counter running 0..SEC_DIV-1.
- FSM:
  - IDLE: shows START_TIME. start -> RUN.
  - RUN:
    - Second counter increments each cycle.
    - At SEC_DIV-1 the counter wraps to 0 and the shot clock decrements by 1 (BCD borrow).
    - If the shot clock is 1 at that tick: it becomes 0, state -> DONE, time_up pulses.
    - Else if pause=1 -> PAUSE.
  - PAUSE: second counter and shot clock hold their values. pause=0 -> RUN, continuing from the held count.
  - DONE:
    - Blink counter runs 0..BLINK_DIV-1 and toggles a blink phase (initially "on") at each wrap.
    - Phase on: d1=F, d0=0. Phase off: d1=F, d0=F.
    - Score holds.
    - start -> RUN.
- Start and reset behaviour:
  - start in any state, including mid-countdown or PAUSE: reload START_TIME, clear the second and blink counters, state=RUN. Score is not cleared.
  - start has priority over pause and over an expiry tick in the same cycle.
- Leading-zero blanking (outside DONE):
  - d3=F when score<10.
  - d1=F when shot clock<10.
  - Ones digits are never blanked.
- rst asserted mid-operation returns to the full reset state on the next edge, regardless of any other input.

Test Plan:
Sim parameters: SCAN_DIV=4, SEC_DIV=8, BLINK_DIV=4, START_TIME=12.
1. Reset/scan:
   - Stimulus: hold rst 3 cycles, then release; observe 20 cycles.
   - Response: d3..d0 = F,0,1,2 and state=0. scan_en pulses on post-reset cycles 4, 8, 12, 16, 20, each 1 cycle wide.
2. Countdown/expiry:
   - Stimulus: pulse start.
   - Response: state=1. Shot clock reads 11 after 8 cycles and 09 (d1=F, d0=9) after 24 cycles. After 96 cycles time_up is a 1-cycle pulse, state=3, d1/d0 = F/0.
   - Then d0 alternates 0 and F every 4 cycles.
3. Pause:
   - Stimulus: in RUN, second counter at 5, assert pause for 20 cycles, then release.
   - Response: state=2 and the shot clock is frozen. The next decrement occurs 3 cycles after release.
4. Score:
   - Stimulus: in RUN, 12 score_inc pulses.
   - Response: d3,d2 = 1,2.
   - Stimulus: 100 pulses total.
   - Response: saturates at 9,9.
   - Stimulus: score_inc and score_clr in the same cycle.
   - Response: F,0.
   - Stimulus: score_inc in IDLE.
   - Response: ignored.
5. Restart priority:
   - Stimulus: start coincident with pause=1 while clock=5.
   - Response: state=1, d1/d0 = 1/2, second counter restarts.
   - Stimulus: start on the expiry tick.
   - Response: no time_up pulse, reload to 12.
6. Mid-run reset:
   - Stimulus: rst during DONE blink-off with score 7.
   - Response: next cycle outputs F,0,1,2, state=0, time_up=0.
